// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states,
// opcode/funct constants, datapath mux encodings and the per-state
// control word.
package multicycle_pkg;

    typedef enum logic [3:0] {
        ST_RESET     = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_READ  = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_MEM_WRITE = 4'd6,
        ST_R_EXEC    = 4'd7,
        ST_R_WB      = 4'd8,
        ST_I_EXEC    = 4'd9,
        ST_I_WB      = 4'd10,
        ST_BRANCH    = 4'd11,
        ST_JUMP      = 4'd12,
        ST_JR        = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    // aluOP encodings, shared with alu_ctrl
    localparam logic [1:0] FORCE_ADD      = 2'b00;
    localparam logic [1:0] FORCE_SUBTRACT = 2'b01;
    localparam logic [1:0] FORCE_PASS     = 2'b10;

    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_REG    = 2'b11;

    typedef enum logic [2:0] {
        CLS_MEM,
        CLS_R,
        CLS_JR,
        CLS_BR,
        CLS_J,
        CLS_IMM,
        CLS_ILLEGAL
    } inst_class_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // Moore control word for a state; everything not listed stays 0.
    function automatic ctrl_t ctrl_for_state(state_t s, logic is_bne);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = SRC_B_FOUR;
            end
            ST_DECODE: c.alu_src_b = SRC_B_IMM_SH2;
            ST_MEM_ADDR, ST_I_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = FORCE_ADD;
            end
            ST_MEM_READ: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            ST_MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            ST_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = FORCE_PASS;
            end
            ST_R_WB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            ST_I_WB: c.reg_write = 1'b1;
            ST_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = FORCE_SUBTRACT;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PC_SRC_ALUOUT;
                c.branch_ne     = is_bne;
            end
            ST_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PC_SRC_JUMP;
            end
            ST_JR: begin
                c.pc_write  = 1'b1;
                c.pc_source = PC_SRC_REG;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Opcode classifier for the DECODE dispatch of multicycle_ctrl.
import multicycle_pkg::*;

module mc_op_decode (
    input  logic [5:0]  op_i,
    input  logic [5:0]  func_i,
    output inst_class_t class_o
);

    // Map opcode (and funct for R-type) to an instruction class
    always_comb begin
        // NOTE: default assignment first so no path leaves class_o unassigned (no latch).
        class_o = CLS_ILLEGAL;
        case (op_i)
            OP_LW, OP_SW:   class_o = CLS_MEM;
            OP_RTYPE:       class_o = (func_i == FUNCT_JR) ? CLS_JR : CLS_R;
            OP_BEQ, OP_BNE: class_o = CLS_BR;
            OP_J:           class_o = CLS_J;
            OP_ADDI:        class_o = CLS_IMM;
            default:        class_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath. Outputs are registered
// Moore decodes of the next state. Optional memory wait states are enabled
// by defining MC_MEM_WAIT_EN, which adds the mem_ready port.
import multicycle_pkg::*;

module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] func,
`ifdef MC_MEM_WAIT_EN
    input  logic       mem_ready,
`endif
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] aluOP,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t      state_q, state_d;
    ctrl_t       ctrl_q;
    logic        illegal_op_q;
    inst_class_t inst_class;
    logic        mem_done;
    logic        fetch_gate;

`ifdef MC_MEM_WAIT_EN
    assign mem_done = mem_ready;
`else
    assign mem_done = 1'b1;
`endif

    mc_op_decode u_decode (
        .op_i    (op),
        .func_i  (func),
        .class_o (inst_class)
    );

    // Next-state selection; unknown encodings fall back to FETCH
    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_RESET:     state_d = ST_FETCH;
            ST_FETCH:     state_d = mem_done ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (inst_class)
                    CLS_MEM: state_d = ST_MEM_ADDR;
                    CLS_R:   state_d = ST_R_EXEC;
                    CLS_JR:  state_d = ST_JR;
                    CLS_BR:  state_d = ST_BRANCH;
                    CLS_J:   state_d = ST_JUMP;
                    CLS_IMM: state_d = ST_I_EXEC;
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MEM_ADDR:  state_d = (op == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
            ST_MEM_READ:  state_d = mem_done ? ST_MEM_WB : ST_MEM_READ;
            ST_MEM_WB:    state_d = ST_FETCH;
            ST_MEM_WRITE: state_d = mem_done ? ST_FETCH : ST_MEM_WRITE;
            ST_R_EXEC:    state_d = ST_R_WB;
            ST_R_WB:      state_d = ST_FETCH;
            ST_I_EXEC:    state_d = ST_I_WB;
            ST_I_WB:      state_d = ST_FETCH;
            ST_BRANCH:    state_d = ST_FETCH;
            ST_JUMP:      state_d = ST_FETCH;
            ST_JR:        state_d = ST_FETCH;
            default:      state_d = ST_FETCH;
        endcase
    end

    // State register, registered control word and sticky illegal flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: async reset clears the control word too, so no strobe outlives rst.
            state_q      <= ST_RESET;
            ctrl_q       <= '0;
            illegal_op_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register sees pre-edge values.
            state_q <= state_d;
            ctrl_q  <= ctrl_for_state(state_d, op == OP_BNE);
            if (state_q == ST_DECODE && inst_class == CLS_ILLEGAL) begin
                illegal_op_q <= 1'b1;
            end
        end
    end

    // IR and PC only load in the FETCH cycle where memory delivers the word.
    assign fetch_gate = (state_q != ST_FETCH) || mem_done;

    assign pc_write      = ctrl_q.pc_write & fetch_gate;
    assign ir_write      = ctrl_q.ir_write & fetch_gate;
    assign pc_write_cond = ctrl_q.pc_write_cond;
    assign branch_ne     = ctrl_q.branch_ne;
    assign iord          = ctrl_q.iord;
    assign mem_read      = ctrl_q.mem_read;
    assign mem_write     = ctrl_q.mem_write;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign reg_dst       = ctrl_q.reg_dst;
    assign reg_write     = ctrl_q.reg_write;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign aluOP         = ctrl_q.alu_op;
    assign pc_source     = ctrl_q.pc_source;
    assign illegal_op    = illegal_op_q;
    assign state         = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl. Expected per-cycle control
// vectors are queued as each instruction is issued and popped once per clock.
// Wait-state steps are included when MC_MEM_WAIT_EN is defined.
import multicycle_pkg::*;

module tb_multicycle_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic [5:0] func;
`ifdef MC_MEM_WAIT_EN
    logic       mem_ready;
`endif
    logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
    logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, aluOP, pc_source;
    logic [3:0] state;

    multicycle_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .op            (op),
        .func          (func),
`ifdef MC_MEM_WAIT_EN
        .mem_ready     (mem_ready),
`endif
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_ne     (branch_ne),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .aluOP         (aluOP),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    // Observed vector: {pcw pcwc bne iord mr mw irw m2r rdst rw asa, asb, aop, psrc, ill, state}
    wire [21:0] obs = {pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write,
                       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                       alu_src_b, aluOP, pc_source, illegal_op, state};

    typedef struct {
        string       tag;
        logic [21:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic ill_exp = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // Expected Moore outputs per state, straight from the state table.
    function automatic logic [21:0] exp_vec(state_t s, logic bne, logic ill, logic rdy);
        logic [10:0] b;
        logic [1:0]  asb;
        logic [1:0]  aop;
        logic [1:0]  ps;
        logic [3:0]  st;
        b = '0; asb = 2'b00; aop = 2'b00; ps = 2'b00; st = s;
        case (s)
            ST_FETCH:     begin b = rdy ? 11'b10001010000 : 11'b00001000000; asb = 2'b01; end
            ST_DECODE:    asb = 2'b11;
            ST_MEM_ADDR:  begin b = 11'b00000000001; asb = 2'b10; aop = 2'b00; end
            ST_MEM_READ:  b = 11'b00011000000;
            ST_MEM_WB:    b = 11'b00000001010;
            ST_MEM_WRITE: b = 11'b00010100000;
            ST_R_EXEC:    begin b = 11'b00000000001; aop = 2'b10; end
            ST_R_WB:      b = 11'b00000000110;
            ST_I_EXEC:    begin b = 11'b00000000001; asb = 2'b10; aop = 2'b00; end
            ST_I_WB:      b = 11'b00000000010;
            ST_BRANCH:    begin b = {2'b01, bne, 8'b00000001}; aop = 2'b01; ps = 2'b01; end
            ST_JUMP:      begin b = 11'b10000000000; ps = 2'b10; end
            ST_JR:        begin b = 11'b10000000000; ps = 2'b11; end
            default:      b = '0;
        endcase
        return {b, asb, aop, ps, ill, st};
    endfunction

    task automatic check(input string tag, input logic [21:0] o, input logic [21:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic push(input string tag, input state_t s,
                        input logic bne = 1'b0, input logic rdy = 1'b1);
        exp_t e;
        e.tag = tag;
        e.v   = exp_vec(s, bne, ill_exp, rdy);
        exp_q.push_back(e);
    endtask

    // Compare the head of the scoreboard against the current outputs.
    task automatic peek_check();
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_underflow: observed=empty expected=entry");
        end else begin
            e = exp_q.pop_front();
            #1;
            check(e.tag, obs, e.v);
        end
    endtask

    task automatic step();
        peek_check();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        while (exp_q.size() > 0) step();
    endtask

    task automatic release_reset();
        @(negedge clk);
        check("rst_hold", obs, exp_vec(ST_RESET, 1'b0, 1'b0, 1'b1));
        rst = 1'b0;
        ill_exp = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        op   = 6'b000000;
        func = 6'b000000;
`ifdef MC_MEM_WAIT_EN
        mem_ready = 1'b1;
`endif
        // Reset held three cycles: all outputs zero, state RESET.
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_zero", obs, exp_vec(ST_RESET, 1'b0, 1'b0, 1'b1));
        end
        release_reset();

        // R-type sub: 4 cycles, aluOP=10 in R_EXEC, rd write-back.
        op = OP_RTYPE; func = 6'b100010;
        push("r_fetch", ST_FETCH); push("r_dec", ST_DECODE);
        push("r_exec", ST_R_EXEC); push("r_wb", ST_R_WB);
        drain();

        // lw: 5 cycles through MEM_READ and MEM_WB.
        op = OP_LW;
        push("lw_fetch", ST_FETCH); push("lw_dec", ST_DECODE); push("lw_addr", ST_MEM_ADDR);
        push("lw_read", ST_MEM_READ); push("lw_wb", ST_MEM_WB);
        drain();

        // sw: 4 cycles.
        op = OP_SW;
        push("sw_fetch", ST_FETCH); push("sw_dec", ST_DECODE); push("sw_addr", ST_MEM_ADDR);
        push("sw_write", ST_MEM_WRITE);
        drain();

        // addi: 4 cycles.
        op = OP_ADDI;
        push("addi_fetch", ST_FETCH); push("addi_dec", ST_DECODE);
        push("addi_exec", ST_I_EXEC); push("addi_wb", ST_I_WB);
        drain();

        // bne then beq: branch_ne follows the opcode.
        op = OP_BNE;
        push("bne_fetch", ST_FETCH); push("bne_dec", ST_DECODE); push("bne_br", ST_BRANCH, 1'b1);
        drain();
        op = OP_BEQ;
        push("beq_fetch", ST_FETCH); push("beq_dec", ST_DECODE); push("beq_br", ST_BRANCH, 1'b0);
        drain();

        // j and jr.
        op = OP_J;
        push("j_fetch", ST_FETCH); push("j_dec", ST_DECODE); push("j_jump", ST_JUMP);
        drain();
        op = OP_RTYPE; func = FUNCT_JR;
        push("jr_fetch", ST_FETCH); push("jr_dec", ST_DECODE); push("jr_jr", ST_JR);
        drain();

        // Illegal opcode: 2 cycles, flag sticks through later instructions.
        op = 6'b111111;
        push("ill_fetch", ST_FETCH); push("ill_dec", ST_DECODE);
        drain();
        ill_exp = 1'b1;
        op = OP_RTYPE; func = 6'b100000;
        push("ill_r_fetch", ST_FETCH); push("ill_r_dec", ST_DECODE);
        push("ill_r_exec", ST_R_EXEC); push("ill_r_wb", ST_R_WB);
        drain();

        // Reset during MEM_WRITE drops the strobe and the sticky flag at once.
        op = OP_SW;
        push("ab_fetch", ST_FETCH); push("ab_dec", ST_DECODE); push("ab_addr", ST_MEM_ADDR);
        drain();
        push("ab_write", ST_MEM_WRITE);
        peek_check();
        #1 rst = 1'b1;
        #1 check("abort_zero", obs, exp_vec(ST_RESET, 1'b0, 1'b0, 1'b1));
        release_reset();
        push("post_rst_fetch", ST_FETCH);
        step();

`ifdef MC_MEM_WAIT_EN
        // Enter a fresh FETCH, then stall it two cycles and MEM_WRITE two cycles.
        op = OP_RTYPE; func = 6'b100000;
        push("wr_dec", ST_DECODE); push("wr_exec", ST_R_EXEC); push("wr_wb", ST_R_WB);
        drain();
        op = OP_SW; mem_ready = 1'b0;
        push("w_fetch_wait", ST_FETCH, 1'b0, 1'b0); step();
        push("w_fetch_wait", ST_FETCH, 1'b0, 1'b0); step();
        mem_ready = 1'b1;
        push("w_fetch_go", ST_FETCH); step();
        push("w_dec", ST_DECODE); step();
        push("w_addr", ST_MEM_ADDR); step();
        mem_ready = 1'b0;
        push("w_write_wait", ST_MEM_WRITE); step();
        push("w_write_wait", ST_MEM_WRITE); step();
        mem_ready = 1'b1;
        push("w_write_go", ST_MEM_WRITE); step();
        // Eight cycles after the stalled fetch began, the next fetch starts.
        push("w_fetch_done", ST_FETCH); step();
        op = OP_SW;
        push("wa_dec", ST_DECODE); push("wa_addr", ST_MEM_ADDR);
        drain();
        mem_ready = 1'b0;
        push("wa_write_wait", ST_MEM_WRITE); step();
        push("wa_write_wait", ST_MEM_WRITE);
        peek_check();
        #1 rst = 1'b1;
        #1 check("wait_abort_zero", obs, exp_vec(ST_RESET, 1'b0, 1'b0, 1'b1));
        mem_ready = 1'b1;
        release_reset();
        push("w_post_rst_fetch", ST_FETCH);
        step();
`endif

        check("scoreboard_empty", 22'(exp_q.size()), 22'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multicycle MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and write-back states and drives every datapath enable and mux select. Sits directly upstream of `alu_ctrl`: its `aluOP` output selects force-add (00), force-subtract (01) or funct pass-through (10). Outputs are Moore, decoded from the state register only.

## Interface

Parameters:
- None. Encodings live in the shared package.

Ports:
- `clk`  in  1  single system clock; all state changes on rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `op`  in  6  instruction opcode from the IR, valid from DECODE onward
- `func`  in  6  R-type funct from the IR, valid from DECODE onward
- `mem_ready`  in  1  memory access complete; present only with `MC_MEM_WAIT_EN`
- `pc_write`, `pc_write_cond`, `branch_ne`  out  1 each  PC write enable, branch-conditional enable, invert zero test
- `iord`, `mem_read`, `mem_write`, `ir_write`  out  1 each  memory address select (1 = ALUOut), read strobe, write strobe, IR load
- `mem_to_reg`, `reg_dst`, `reg_write`  out  1 each  write-back data select, destination select (1 = rd), register file write
- `alu_src_a`  out  1  0 = PC, 1 = A
- `alu_src_b`  out  2  00 = B, 01 = 4, 10 = sign-ext imm, 11 = imm<<2
- `aluOP`  out  2  to `alu_ctrl`
- `pc_source`  out  2  00 = ALU, 01 = ALUOut, 10 = jump target, 11 = A
- `illegal_op`  out  1  sticky: unsupported opcode decoded
- `state`  out  4  current state encoding, debug

## Operation

Outputs are 0 in every state unless listed below.

- RESET: all outputs 0. Entered asynchronously on `rst`; on the first edge after `rst` deasserts, moves to FETCH.
- FETCH: `mem_read`=1, `ir_write`=1, `alu_src_b`=01, `pc_write`=1. Then DECODE.
- DECODE: `alu_src_b`=11 (branch target into ALUOut). Dispatch:
  - lw 100011 or sw 101011: MEM_ADDR
  - `op` 000000 with `func` 001000: JR
  - any other `op` 000000: R_EXEC
  - beq 000100 or bne 000101: BRANCH
  - j 000010: JUMP
  - addi 001000: I_EXEC
  - anything else: set `illegal_op`, then FETCH
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: `mem_read`=1, `iord`=1. Then MEM_WB.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1. Then FETCH.
- MEM_WRITE: `mem_write`=1, `iord`=1. Then FETCH.
- R_EXEC: `alu_src_a`=1, `aluOP`=10. Then R_WB.
- R_WB: `reg_dst`=1, `reg_write`=1. Then FETCH.
- I_EXEC: `alu_src_a`=1, `alu_src_b`=10, `aluOP`=00. Then I_WB.
- I_WB: `reg_write`=1. Then FETCH.
- BRANCH: `alu_src_a`=1, `aluOP`=01, `pc_write_cond`=1, `pc_source`=01, `branch_ne`=(`op`==000101). Then FETCH.
- JUMP: `pc_write`=1, `pc_source`=10. Then FETCH.
- JR: `pc_write`=1, `pc_source`=11. Then FETCH.
- `illegal_op` clears only on reset.
- Undefined state encodings recover to FETCH.

## Timing

- Cycles per instruction, counted from entering FETCH with no wait states: lw 5; sw, R-type, addi 4; beq/bne, j, jr 3; illegal 2.
- `op` and `func` are sampled only in DECODE, BRANCH and MEM_ADDR. They must stay stable until the next FETCH.
- Reset mid-instruction aborts immediately. Outputs go to 0 asynchronously and no partial write strobe survives.

## Configuration

- `MC_MEM_WAIT_EN` defined:
  - Port `mem_ready` exists.
  - FETCH, MEM_READ and MEM_WRITE hold, with strobes asserted, until `mem_ready`=1.
  - In FETCH, `ir_write` and `pc_write` are asserted only in the cycle where `mem_ready`=1.
  - MEM_WRITE holds `mem_write` for every wait cycle.
- `MC_MEM_WAIT_EN` undefined: port absent; every memory state lasts exactly one cycle.

## Structure

- Package `multicycle_pkg` holds:
  - state enum (4-bit)
  - opcode and JR funct constants
  - `aluOP` encodings FORCE_ADD/FORCE_SUBTRACT/FORCE_PASS, shared with `alu_ctrl`
  - `alu_src_b` and `pc_source` encodings
- One sub-module, `mc_op_decode`: combinational classifier from `op`/`func` to an instruction class (MEM, R, JR, BR, J, IMM, ILLEGAL). Used by the DECODE transition.

## Test plan

- Reset held 3 cycles, released: all outputs 0 during reset; `state`=FETCH one edge later, with `mem_read`=1, `pc_write`=1, `alu_src_b`=01.
- `op`=000000, `func`=100010: `aluOP`=10 in R_EXEC, `reg_dst`=1 and `reg_write`=1 in cycle 4, back in FETCH at cycle 5.
- `op`=100011: `aluOP`=00 and `alu_src_b`=10 in MEM_ADDR; `iord`=1 for MEM_READ; `mem_to_reg`=1 in cycle 5; total 5 cycles.
- `op`=000101: BRANCH shows `aluOP`=01, `branch_ne`=1, `pc_write_cond`=1, `pc_source`=01. `op`=000010 instead: JUMP shows `pc_source`=10, `pc_write`=1.
- `op`=111111: `illegal_op`=1 after DECODE and stays high through the following instructions until `rst`.
- With `MC_MEM_WAIT_EN`, `mem_ready` low for 2 cycles during FETCH and during MEM_WRITE of sw: `state` holds 3 cycles in each; `ir_write` pulses once; sw takes 8 cycles. Asserting `rst` during the wait forces `mem_write`=0 immediately.
